// File: rtl/ripple_count_capture.sv
// ripple_count_capture
//   Reads a free-running asynchronous ripple counter into the clk domain.
//   Each bit is synchronised on its own. A value is accepted only after the
//   synchronised sample has stayed unchanged for STABLE_CYCLES samples, so
//   ripple skew between bits never shows up as a bogus count. The block
//   publishes the accepted count and a wrap pulse. It also offers snapshots
//   (count plus delta since the last consumed snapshot) over valid/ready.
//
// Ports
//   clk           in   1      system clock, rising edge
//   rst_n         in   1      asynchronous reset, active-low
//   cnt_in        in   WIDTH  ripple counter outputs (asynchronous to clk)
//   stable_count  out  WIDTH  last accepted count
//   stable        out  1      synced sample settled (stability run saturated)
//   wrap_pulse    out  1      1-cycle pulse when an accepted value is below the old count
//   snap_req      in   1      snapshot request, sampled only in IDLE
//   snap_valid    out  1      snapshot held and presented
//   snap_ready    in   1      consumer accepts the snapshot
//   snap_count    out  WIDTH  captured count
//   snap_delta    out  WIDTH  (snap_count - last_read) mod 2^WIDTH
//   err_clr       in   1      clears err_sticky
//   err_sticky    out  1      input failed to settle for MAX_UNSTABLE consecutive cycles
//
// Handshake: a snapshot transfers on any rising edge where snap_valid and
// snap_ready are both 1. snap_valid comes only from the state register and
// never depends combinationally on snap_ready. Once raised, snap_valid holds
// its payload until the transfer edge.
module ripple_count_capture #(
    parameter int WIDTH         = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 3,
    parameter int MAX_UNSTABLE  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] stable_count,
    output logic             stable,
    output logic             wrap_pulse,
    input  logic             snap_req,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic [WIDTH-1:0] snap_count,
    output logic [WIDTH-1:0] snap_delta,
    input  logic             err_clr,
    output logic             err_sticky
);

    localparam int RUN_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int UNS_W = $clog2(MAX_UNSTABLE + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(STABLE_CYCLES - 2);
    localparam logic [UNS_W-1:0] UNS_MAX = UNS_W'(MAX_UNSTABLE);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] samp;
    logic [WIDTH-1:0] prev_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_nxt;
    logic [UNS_W-1:0] uns_q;
    logic [UNS_W-1:0] uns_nxt;
    logic [WIDTH-1:0] last_read;
    logic             same;
    logic             accept;
    logic             capture;
    logic [WIDTH-1:0] capture_val;
    logic             consume;

    assign samp   = sync_q[SYNC_STAGES-1];
    assign same   = (samp == prev_q);
    // The accept edge is the one that takes the run to saturation. So the
    // count loads exactly once per settle, on the same edge that stable rises.
    assign accept = same && (run_q == RUN_PRE);
    assign stable = (run_q == RUN_MAX);
    assign snap_valid = (state == ST_PRESENT);

    always_comb begin
        run_nxt = run_q;
        uns_nxt = uns_q;
        if (!same) begin
            run_nxt = '0;
            uns_nxt = (uns_q == UNS_MAX) ? uns_q : uns_q + UNS_W'(1);
        end else begin
            run_nxt = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
            uns_nxt = '0;
        end
    end

    // Snapshot FSM: next state and capture/consume strobes.
    always_comb begin
        state_nxt   = state;
        capture     = 1'b0;
        capture_val = stable_count;
        consume     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (snap_req) begin
                    if (stable) begin
                        capture     = 1'b1;
                        capture_val = stable_count;
                        state_nxt   = ST_PRESENT;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Take the value being accepted this edge, not the old count.
                if (accept) begin
                    capture     = 1'b1;
                    capture_val = samp;
                    state_nxt   = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (snap_ready) begin
                    consume   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= cnt_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            prev_q       <= '0;
            run_q        <= '0;
            uns_q        <= '0;
            stable_count <= '0;
            wrap_pulse   <= 1'b0;
            err_sticky   <= 1'b0;
            snap_count   <= '0;
            snap_delta   <= '0;
            last_read    <= '0;
        end else begin
            state      <= state_nxt;
            prev_q     <= samp;
            run_q      <= run_nxt;
            uns_q      <= uns_nxt;
            wrap_pulse <= accept && (samp < stable_count);
            if (accept) begin
                stable_count <= samp;
            end
            // Set has priority over clear.
            err_sticky <= (uns_nxt == UNS_MAX) || (err_sticky && !err_clr);
            if (capture) begin
                snap_count <= capture_val;
                snap_delta <= capture_val - last_read;
            end
            if (consume) begin
                last_read <= snap_count;
            end
        end
    end

endmodule
